fpdiv32_seq: RTL and testbench
==============================

FPDIV32_SEQ -- requirements
Module: fpdiv32_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 input_a  input  32  IEEE-754 single dividend.
REQ-006 input_b  input  32  IEEE-754 single divisor.
REQ-007 div_output  output  32  quotient input_a / input_b, registered.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; div_output is valid from this cycle.

Function
REQ-010 The block SHALL use four states: IDLE, DIVIDE, NORM and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch input_a and input_b and classify them.
- Special case: go to DONE.
- Otherwise: go to DIVIDE.
REQ-012 The block SHALL ignore start in DIVIDE, NORM and DONE; it SHALL NOT queue it.
REQ-013 Special-case priority, first match wins:
- a or b NaN -> 0xFFC00000.
- Inf/Inf or 0/0 -> 0xFFC00000.
- a Inf -> Inf, sign a^b.
- b Inf -> zero, sign a^b.
- b zero -> Inf, sign a^b.
- a zero -> zero, sign a^b.
REQ-014 The block SHALL treat denormal inputs (exp=0, mantissa!=0) as zero.
REQ-015 DIVIDE SHALL be a restoring mantissa divide over exactly 25 cycles.
- Remainder starts at ma={1,a[22:0]}; mb={1,b[22:0]}.
- Each cycle: if remainder>=mb, quotient bit=1 and remainder-=mb; then shift remainder left 1.
- Result: 25-bit q=floor(ma*2^24/mb).
REQ-016 The exponent SHALL be computed as 10-bit signed: e=ea-eb+126.
REQ-017 NORM SHALL normalise the quotient.
- q[24]=1: mantissa=q[23:1], e=e+1.
- q[24]=0: mantissa=q[22:0].
REQ-018 Rounding SHALL be truncation (round toward zero).
REQ-019 NORM SHALL handle range limits.
- e>=255 -> Inf, sign a^b.
- e<=0 -> zero, sign a^b (flush, no denormal output).
REQ-020 The output sign SHALL always be a[31]^b[31], except for NaN.
REQ-021 div_output SHALL be loaded on entry to DONE.
- It holds its value until the next DONE entry.
- done=(state==DONE).
REQ-022 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-023 Latency, counted from the start cycle c0:
- Normal: done high in cycle c0+27.
- Special: done high in cycle c0+1.
- Next start is accepted at the earliest in c0+28 (normal) or c0+2 (special).

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL apply these values, overriding any other action:
- state=IDLE, div_output=0, busy=0, done=0.
- Latched operands, quotient, remainder and counter cleared.
REQ-025 Reset during DIVIDE or NORM SHALL abort the operation.
- No done pulse.
- div_output=0.

Structure
REQ-026 Shared package fp32_pkg SHALL hold:
- Field widths (sign 1, exponent 8, mantissa 23).
- Bias 127.
- NAN_CANON=0xFFC00000, POS_INF=0x7F800000.
- The state enumeration.
REQ-027 The block SHALL contain one sub-module, mant_div24.
- Function: 25-iteration restoring divider core with its own 5-bit iteration counter.
- Handshake: load/finish with the top FSM.
REQ-028 Special-case classification SHALL stay in the top level.

Verification
REQ-029 0x40C00000 / 0x40000000 (6/2) -> div_output=0x40400000, done in c0+27, busy high c1..c27.
REQ-030 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB).
REQ-031 Specials, each with done in c0+1:
- 0x3F800000 / 0x00000000 -> 0x7F800000.
- 0x00000000 / 0x00000000 -> 0xFFC00000.
- 0x7FC00000 / any -> 0xFFC00000.
REQ-032 0x7F000000 / 0x3E800000 (overflow) -> 0x7F800000.
REQ-033 0x00800000 / 0x4B000000 (underflow) -> 0x00000000.
REQ-034 Control cases:
- start pulsed during DIVIDE -> ignored, single done.
- rst asserted in cycle c10 -> IDLE next cycle, no done, div_output=0.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and the divider FSM state type.
package fp32_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] NAN_CANON = 32'hFFC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;

    // Quotient exponent offset: bias minus one, because the mantissa quotient
    // lands in [0.5, 2) and is normalised by bumping the exponent when >= 1.
    localparam logic signed [9:0] EXP_OFFSET = 10'(BIAS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mant_div24.sv
// 25-iteration restoring divider for 24-bit normalised mantissas.
// load captures the operands; finish is high during the last iteration cycle,
// after which quotient holds floor(dividend * 2^24 / divisor).
module mant_div24
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic        finish,
    output logic [24:0] quotient
);

    logic [24:0] rem;
    logic [23:0] dvs;
    logic [4:0]  cnt;
    logic        active;

    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    // One restoring step: subtract when the remainder covers the divisor, then shift.
    always_comb begin
        rem_ge   = (rem >= {1'b0, dvs});
        rem_sub  = rem_ge ? (rem - {1'b0, dvs}) : rem;
        rem_next = {rem_sub[23:0], 1'b0};
    end

    assign finish = active && (cnt == 5'd24);

    // Iteration state: operands, partial remainder, quotient bits and counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            quotient <= '0;
        end else if (load) begin
            rem      <= {1'b0, dividend};
            dvs      <= divisor;
            cnt      <= '0;
            active   <= 1'b1;
            quotient <= '0;
        end else if (active) begin
            rem      <= rem_next;
            quotient <= {quotient[23:0], rem_ge};
            cnt      <= cnt + 5'd1;
            if (cnt == 5'd24)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/fpdiv32_seq.sv
// Sequential IEEE-754 single-precision divider: special-case classification,
// a 25-cycle mantissa divide, normalisation with truncation, flush-to-zero.
module fpdiv32_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic [31:0] div_output,
    output logic        busy,
    output logic        done
);

    state_t state, state_next;

    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sign_in;
    logic              is_special;
    logic [31:0]       special_result;
    logic signed [9:0] exp_start;

    logic              sign_q;
    logic signed [9:0] exp_q;

    logic              div_load;
    logic              div_finish;
    logic [24:0]       div_q;

    logic signed [9:0]  exp_norm;
    logic [MANT_W-1:0]  mant_norm;
    logic [31:0]        norm_result;

    logic               out_load;
    logic [31:0]        out_value;

    assign a_exp  = input_a[MANT_W +: EXP_W];
    assign b_exp  = input_b[MANT_W +: EXP_W];
    assign a_mant = input_a[MANT_W-1:0];
    assign b_mant = input_b[MANT_W-1:0];

    // Denormals have exponent zero and are deliberately treated as zero.
    assign a_nan   = (a_exp == '1) && (a_mant != '0);
    assign b_nan   = (b_exp == '1) && (b_mant != '0);
    assign a_inf   = (a_exp == '1) && (a_mant == '0);
    assign b_inf   = (b_exp == '1) && (b_mant == '0);
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign sign_in = input_a[31] ^ input_b[31];

    assign exp_start = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + EXP_OFFSET;

    // Special-case classification of the live inputs, first match wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        is_special     = 1'b1;
        special_result = NAN_CANON;
        if (a_nan || b_nan)
            special_result = NAN_CANON;
        else if ((a_inf && b_inf) || (a_zero && b_zero))
            special_result = NAN_CANON;
        else if (a_inf)
            special_result = {sign_in, POS_INF[30:0]};
        else if (b_inf)
            special_result = {sign_in, 31'b0};
        else if (b_zero)
            special_result = {sign_in, POS_INF[30:0]};
        else if (a_zero)
            special_result = {sign_in, 31'b0};
        else
            is_special = 1'b0;
    end

    mant_div24 u_mant_div24 (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend ({1'b1, a_mant}),
        .divisor  ({1'b1, b_mant}),
        .finish   (div_finish),
        .quotient (div_q)
    );

    // Normalise the quotient, truncate, and clamp to Inf / flush to zero.
    always_comb begin
        exp_norm  = div_q[24] ? (exp_q + 10'sd1) : exp_q;
        mant_norm = div_q[24] ? div_q[23:1] : div_q[22:0];
        if (exp_norm >= 10'sd255)
            norm_result = {sign_q, POS_INF[30:0]};
        else if (exp_norm <= 10'sd0)
            norm_result = {sign_q, 31'b0};
        else
            norm_result = {sign_q, exp_norm[EXP_W-1:0], mant_norm};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic plus divider load and result load strobes.
    always_comb begin
        state_next = state;
        div_load   = 1'b0;
        out_load   = 1'b0;
        out_value  = norm_result;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (is_special) begin
                        state_next = DONE;
                        out_load   = 1'b1;
                        out_value  = special_result;
                    end else begin
                        state_next = DIVIDE;
                        div_load   = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (div_finish)
                    state_next = NORM;
            end
            NORM: begin
                state_next = DONE;
                out_load   = 1'b1;
                out_value  = norm_result;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand-derived sign/exponent capture and the registered result.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every datapath register, so an aborted divide
        // leaves no stale exponent, sign or result behind.
        if (rst) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            div_output <= '0;
        end else begin
            if (state == IDLE && start) begin
                sign_q <= sign_in;
                exp_q  <= exp_start;
            end
            if (out_load)
                div_output <= out_value;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fpdiv32_seq.sv
// Directed bench for fpdiv32_seq with hand-computed quotients and latencies.
module tb_fpdiv32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] div_output;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    fpdiv32_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .input_a    (input_a),
        .input_b    (input_b),
        .div_output (div_output),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one operation at the next falling edge and follow it to done.
    // Returns with the bench parked at the falling edge of the done cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int  cyc;
        bit  busy_ok;
        @(negedge clk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (cyc <= 40) begin
            if (!busy) busy_ok = 1'b0;
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, div_output, exp_res);
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    endtask

    initial begin
        int ndone;
        int done_cyc;

        rst     = 1'b1;
        start   = 1'b0;
        input_a = '0;
        input_b = '0;
        repeat (2) @(negedge clk);
        check("reset div_output", div_output, 32'h0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        // Normal path, back-to-back at the earliest allowed start.
        run_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);
        run_op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27);
        run_op("-6/2",     32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 27);
        run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27);
        run_op("underflow",32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 27);

        // Special cases resolve in one cycle.
        run_op("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1);
        run_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 1);
        run_op("nan/1",    32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 1);
        run_op("inf/inf",  32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000, 1);
        run_op("-inf/2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1);
        run_op("2/-inf",   32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1);
        run_op("-0/2",     32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1);
        run_op("denorm/1", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1);

        // Result holds after done and the block returns to idle.
        run_op("6/2 again", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);
        repeat (3) @(negedge clk);
        check("hold div_output", div_output, 32'h4040_0000);
        check("hold busy", {31'b0, busy}, 32'd0);

        // Start pulsed mid-divide must be ignored, not queued.
        @(negedge clk);
        input_a = 32'h40C0_0000;
        input_b = 32'h4000_0000;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ndone    = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (cyc == 5) begin
                input_a = 32'h3F80_0000;
                input_b = 32'h4040_0000;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        check("ignore start done count", 32'(ndone), 32'd1);
        check("ignore start done cycle", 32'(done_cyc), 32'd27);
        check("ignore start result", div_output, 32'h4040_0000);

        // Reset in c10 aborts the divide with no done pulse.
        input_a = 32'h3F80_0000;
        input_b = 32'h4040_0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort div_output", div_output, 32'h0);
        ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort done count", 32'(ndone), 32'd0);
        check("abort div_output later", div_output, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
